// File: rtl/sys_defs.sv
`default_nettype none
// ============================================================================
// Package : sys_defs
// Purpose : Shared machine-wide definitions: multiplier latency and the
//           execute-complete packet carried from functional units to the CDB.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif

package sys_defs;

  // Completed-op packet; the functional unit stamps result before done.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [5:0]  dest_prn;
    logic [31:0] result;
  } EX_COMPLETE_ENTRY;

endpackage
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : cdb_fifo
// Purpose : Small type-generic FIFO with synchronous clear. The head entry is
//           visible combinationally; push and pop may coincide when full.
// Ports   : clock, reset      - clock / synchronous active-high reset
//           clear             - empties the FIFO (head snaps to tail)
//           push, push_data   - enqueue; ignored when full with no pop
//           pop               - dequeue; ignored when empty
//           head_data         - entry at the head pointer
//           count, full       - occupancy status
// Rev     : 1.0  initial release
// ============================================================================
module cdb_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            w_do_pop;
  logic            w_do_push;

  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_head];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + PW'(1);
      if (w_do_pop)  r_head <= r_head + PW'(1);
      if (w_do_push & ~w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop & ~w_do_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage carries no reset; stale entries are never observed because the
  // consumer gates head_data on count.
  always_ff @(posedge clock) begin
    if (w_do_push & ~clear & ~reset) r_mem[r_tail] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mult_cdb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : mult_cdb_buffer
// Purpose : Completion buffer behind the pipelined multiplier. Buffers
//           finished multiplies, requests the CDB with the oldest one, and
//           keeps issue credit so the FIFO can never be oversubscribed.
//           A flush empties the buffer and marks in-flight ops for discard.
// Ports   : clock, reset  - clock / synchronous active-high reset
//           issue_fire    - multiplier accepted an op this cycle
//           mult_done     - multiplier tail-stage done pulse
//           mult_meta     - completed packet (valid with mult_done)
//           flush         - squash buffered and in-flight results
//           cdb_grant     - CDB accepts the head packet
//           issue_ready   - issue may fire a multiply
//           cdb_req       - head packet valid, CDB requested
//           cdb_packet    - head packet ('0 when empty)
//           overflow      - sticky error flag, cleared only by reset
// Rev     : 1.0  initial release
// ============================================================================
`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif

module mult_cdb_buffer
  import sys_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int STAGES = `MULT_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_fire,
  input  logic             mult_done,
  input  EX_COMPLETE_ENTRY mult_meta,
  input  logic             flush,
  input  logic             cdb_grant,
  output logic             issue_ready,
  output logic             cdb_req,
  output EX_COMPLETE_ENTRY cdb_packet,
  output logic             overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(STAGES+1);
  // Wide enough for drop + inflight + 1 without wrapping.
  localparam int SW = IW + 2;
  localparam int RW = ((CW > IW) ? CW : IW) + 1;

  logic [CW-1:0]    w_count;
  logic             w_full;
  EX_COMPLETE_ENTRY w_head;
  logic [IW-1:0]    r_inflight;
  logic [IW-1:0]    r_drop;
  logic             r_overflow;

  logic             w_pop;
  logic             w_drop_hit;
  logic             w_push;
  logic             w_push_lost;
  logic             w_spurious;
  logic             w_dec;
  logic [SW-1:0]    w_inflight_next;
  logic             w_inflight_over;
  logic [SW-1:0]    w_drop_sum;
  logic [SW-1:0]    w_drop_flush;
  logic [RW-1:0]    w_occupancy;

  cdb_fifo #(
    .T     (EX_COMPLETE_ENTRY),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (w_push),
    .push_data (mult_meta),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count),
    .full      (w_full)
  );

  assign cdb_req     = (w_count != '0) & ~flush;
  assign cdb_packet  = (w_count != '0) ? w_head : '0;
  assign w_occupancy = RW'(w_count) + RW'(r_inflight);
  assign issue_ready = (w_occupancy < RW'(DEPTH)) & ~flush;
  assign overflow    = r_overflow;

  // cdb_req already excludes flush, so a grant during flush does nothing.
  assign w_pop       = cdb_grant & cdb_req;
  assign w_drop_hit  = mult_done & (r_drop != '0);
  assign w_push      = mult_done & ~w_drop_hit & ~flush;
  assign w_push_lost = w_push & w_full & ~w_pop;
  assign w_spurious  = mult_done & (r_inflight == '0) & (r_drop == '0);

  // A completion with no live op recorded cannot retire a credit.
  assign w_dec           = w_push & (r_inflight != '0);
  assign w_inflight_next = SW'(r_inflight) + SW'(issue_fire) - SW'(w_dec);
  assign w_inflight_over = (w_inflight_next > SW'(STAGES));

  // On flush every live op (plus any issued this cycle) becomes a pending
  // discard, less the one completing this cycle.
  always_comb begin
    w_drop_sum   = SW'(r_drop) + SW'(r_inflight) + SW'(issue_fire);
    w_drop_flush = w_drop_sum;
    if (mult_done) begin
      w_drop_flush = (w_drop_sum == '0) ? '0 : w_drop_sum - SW'(1);
    end
    if (w_drop_flush > SW'(STAGES)) begin
      w_drop_flush = SW'(STAGES);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_inflight <= '0;
      r_drop     <= IW'(w_drop_flush);
      if (w_spurious) r_overflow <= 1'b1;
    end else begin
      if (w_drop_hit) r_drop <= r_drop - IW'(1);
      r_inflight <= w_inflight_over ? IW'(STAGES) : IW'(w_inflight_next);
      if (w_inflight_over | w_push_lost | w_spurious) r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_cdb_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_cdb_buffer
// Purpose : Directed self-checking bench for mult_cdb_buffer (DEPTH=4,
//           STAGES=4). Expected values are hand-computed constants.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mult_cdb_buffer;
  import sys_defs::*;

  logic             clock;
  logic             reset;
  logic             issue_fire;
  logic             mult_done;
  EX_COMPLETE_ENTRY mult_meta;
  logic             flush;
  logic             cdb_grant;
  logic             issue_ready;
  logic             cdb_req;
  EX_COMPLETE_ENTRY cdb_packet;
  logic             overflow;

  int errors;
  int checks;

  mult_cdb_buffer #(
    .DEPTH  (4),
    .STAGES (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_fire  (issue_fire),
    .mult_done   (mult_done),
    .mult_meta   (mult_meta),
    .flush       (flush),
    .cdb_grant   (cdb_grant),
    .issue_ready (issue_ready),
    .cdb_req     (cdb_req),
    .cdb_packet  (cdb_packet),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    issue_fire = 1'b0;
    mult_done  = 1'b0;
    mult_meta  = '0;
    flush      = 1'b0;
    cdb_grant  = 1'b0;
  endtask

  // Drive one cycle of inputs, cross the edge, then return to idle inputs.
  task automatic cyc(input logic fire, input logic done, input logic [4:0] rob,
                     input logic [31:0] res, input logic fl, input logic gr);
    issue_fire = fire;
    mult_done  = done;
    mult_meta  = done ? '{valid: 1'b1, rob_idx: rob, dest_prn: 6'(rob), result: res} : '0;
    flush      = fl;
    cdb_grant  = gr;
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_inputs();

    // ---------------- reset ----------------
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_cdb_req",     64'(cdb_req),     64'd0);
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_overflow",    64'(overflow),    64'd0);
    check("rst_packet",      64'(cdb_packet),  64'd0);
    check("rst_count",       64'(dut.w_count), 64'd0);

    // ---------------- single op, grant tied high ----------------
    cyc(1, 0, 0, 0, 0, 1);                       // cycle 0 issue
    repeat (3) cyc(0, 0, 0, 0, 0, 1);            // cycles 1..3
    check("single_inflight", 64'(dut.r_inflight), 64'd1);
    check("single_req_early", 64'(cdb_req), 64'd0);
    cyc(0, 1, 5'd3, 32'h0000_002A, 0, 1);        // cycle 4 done
    check("single_req_c5",    64'(cdb_req), 64'd1);
    check("single_rob_c5",    64'(cdb_packet.rob_idx), 64'd3);
    check("single_result_c5", 64'(cdb_packet.result),  64'h2A);
    check("single_infl_c5",   64'(dut.r_inflight), 64'd0);
    cyc(0, 0, 0, 0, 0, 1);                       // cycle 5 grant
    check("single_req_c6",    64'(cdb_req), 64'd0);
    check("single_pkt_c6",    64'(cdb_packet), 64'd0);

    // ---------------- backpressure ----------------
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    check("bp_ready_credit", 64'(issue_ready), 64'd0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 5'(i), 32'(i * 100), 0, 0);
    check("bp_count",    64'(dut.w_count), 64'd4);
    check("bp_ready",    64'(issue_ready), 64'd0);
    check("bp_inflight", 64'(dut.r_inflight), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_order_%0d", i), 64'(cdb_packet.rob_idx), 64'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end
    check("bp_ready_after", 64'(issue_ready), 64'd1);
    check("bp_req_after",   64'(cdb_req),     64'd0);

    // ---------------- credit limit ----------------
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd5, 32'd5, 0, 0);
    cyc(0, 1, 5'd6, 32'd6, 0, 0);
    check("credit_count",    64'(dut.w_count), 64'd2);
    check("credit_inflight", 64'(dut.r_inflight), 64'd2);
    check("credit_ready_0",  64'(issue_ready), 64'd0);
    cyc(0, 0, 0, 0, 0, 1);
    check("credit_ready_1",  64'(issue_ready), 64'd1);
    cyc(0, 1, 5'd7, 32'd7, 0, 0);
    cyc(0, 1, 5'd8, 32'd8, 0, 0);
    for (int i = 6; i <= 8; i++) begin
      check($sformatf("credit_order_%0d", i), 64'(cdb_packet.rob_idx), 64'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end

    // ---------------- flush ----------------
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd10, 32'd10, 0, 0);
    check("fl_pre_count",    64'(dut.w_count), 64'd1);
    check("fl_pre_inflight", 64'(dut.r_inflight), 64'd2);
    issue_fire = 1'b1;
    flush      = 1'b1;
    cdb_grant  = 1'b1;
    #1;
    check("fl_req_comb",   64'(cdb_req),     64'd0);
    check("fl_ready_comb", 64'(issue_ready), 64'd0);
    @(posedge clock);
    #1;
    clear_inputs();
    check("fl_count",    64'(dut.w_count), 64'd0);
    check("fl_drop",     64'(dut.r_drop), 64'd3);
    check("fl_inflight", 64'(dut.r_inflight), 64'd0);
    cyc(1, 0, 0, 0, 0, 0);                       // op issued after flush
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 5'(20 + i), 32'hDEAD, 0, 0);
      check($sformatf("fl_discard_req_%0d", i), 64'(cdb_req), 64'd0);
      check($sformatf("fl_drop_%0d", i), 64'(dut.r_drop), 64'(2 - i));
    end
    cyc(0, 1, 5'd9, 32'd9, 0, 0);
    check("fl_keep_req", 64'(cdb_req), 64'd1);
    check("fl_keep_rob", 64'(cdb_packet.rob_idx), 64'd9);
    check("fl_keep_inf", 64'(dut.r_inflight), 64'd0);
    check("fl_overflow", 64'(overflow), 64'd0);
    cyc(0, 0, 0, 0, 0, 1);

    // ---------------- simultaneous push/pop when full, then overflow ----------------
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 11; i <= 14; i++) cyc(0, 1, 5'(i), 32'(i), 0, 0);
    check("full_count", 64'(dut.w_count), 64'd4);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd15, 32'd15, 0, 1);
    check("pp_count",    64'(dut.w_count), 64'd4);
    check("pp_head",     64'(cdb_packet.rob_idx), 64'd12);
    check("pp_overflow", 64'(overflow), 64'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd16, 32'd16, 0, 0);
    check("ov_set",   64'(overflow), 64'd1);
    check("ov_count", 64'(dut.w_count), 64'd4);
    check("ov_head",  64'(cdb_packet.rob_idx), 64'd12);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    check("ov_sticky", 64'(overflow), 64'd1);

    // ---------------- reset mid-stream ----------------
    cyc(0, 0, 0, 0, 0, 1);
    check("mid_count", 64'(dut.w_count), 64'd3);
    check("mid_head",  64'(cdb_packet.rob_idx), 64'd13);
    cyc(1, 0, 0, 0, 0, 0);
    check("mid_inflight", 64'(dut.r_inflight), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mr_cdb_req",     64'(cdb_req),     64'd0);
    check("mr_issue_ready", 64'(issue_ready), 64'd1);
    check("mr_overflow",    64'(overflow),    64'd0);
    check("mr_packet",      64'(cdb_packet),  64'd0);
    check("mr_inflight",    64'(dut.r_inflight), 64'd0);
    check("mr_drop",        64'(dut.r_drop),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
